neuron_mac_seq: RTL

//  Parametrised sequential neuron: signed dot product of N inputs and N weights, plus bias.

---
 rtl/neuron_pkg.sv | 34 +++
 rtl/neuron_mac.sv | 36 +++
 rtl/neuron_mac_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and helpers for the sequential neuron.
//   state_t   : FSM state encoding (IDLE, ACC, FIN)
//   acc_width : accumulator width that cannot overflow for N products of DW x DW
//   sat       : clamps a wide signed value to the signed range of ow bits
package neuron_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Width of the accumulator.
   // It holds N full-width products plus one guard bit.
   function automatic int acc_width(input int dw, input int n);
      return 2*dw + $clog2(n) + 1;
   endfunction

   // Clamp s to the signed range [-2**(ow-1), 2**(ow-1)-1].
   // An in-range value is returned unchanged, so the low ow bits are the result.
   function automatic logic signed [63:0] sat(input logic signed [63:0] s, input int ow);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (ow - 1));
      if (s > max_v)
         return max_v;
      else if (s < min_v)
         return min_v;
      else
         return s;
   endfunction

endpackage

// File: rtl/neuron_mac.sv
// neuron_mac: registered signed multiply-accumulate, width AW.
//   clk : rising-edge clock
//   rst : synchronous reset, active-low; clears acc
//   clr : clears acc; takes priority over en
//   en  : adds the sign-extended product a*b to acc
//   a,b : signed DW-bit operands
//   acc : signed AW-bit running sum
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [AW-1:0] acc
);

   logic signed [2*DW-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk) begin
      if (!rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + AW'(prod);   // signed cast sign-extends the product
   end

endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential signed neuron. It computes out = act(sat(sum(in[i]*w[i]) + bias)).
// The block applies one product per clock and fetches operands through idx.
// Optional build macro: NEURON_RELU_EN. When it is defined, negative results are stored as 0.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-low
//   start : starts an evaluation; sampled only in IDLE
//   in, w : signed operands for the current idx; combinational from idx
//   bias  : signed bias; latched when start is accepted
//   idx   : operand index presented to the selection block
//   out   : signed result; valid while ready=1
//   ready : result valid and block idle
//   busy  : evaluation in progress
module neuron_mac_seq
   import neuron_pkg::*;
#(
   parameter int N  = 10,
   parameter int DW = 8,
   parameter int OW = 16,
   parameter int IW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic signed [DW-1:0] in,
   input  logic signed [DW-1:0] w,
   input  logic signed [OW-1:0] bias,
   output logic [IW-1:0]        idx,
   output logic signed [OW-1:0] out,
   output logic                 ready,
   output logic                 busy
);

   localparam int AW = acc_width(DW, N);

   state_t                state_reg;
   logic signed [OW-1:0]  bias_reg;
   logic signed [AW-1:0]  acc;
   logic                  mac_clr;
   logic                  mac_en;
   logic signed [63:0]    s_wide;
   logic signed [63:0]    s_sat;

   // The accumulator is cleared on the same edge that accepts start.
   // ACC then adds exactly N products.
   assign mac_clr = (state_reg == IDLE) && start;
   assign mac_en  = (state_reg == ACC);

   neuron_mac #(
      .DW (DW),
      .AW (AW)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (in),
      .b   (w),
      .acc (acc)
   );

   always_comb begin
      s_wide = 64'(acc) + 64'(bias_reg);
      s_sat  = sat(s_wide, OW);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         bias_reg  <= '0;
         idx       <= '0;
         out       <= '0;
         ready     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  bias_reg  <= bias;
                  idx       <= '0;
                  busy      <= 1'b1;
                  ready     <= 1'b0;
                  state_reg <= ACC;
               end
            end
            ACC: begin
               // idx holds on the last operand so that FIN sees a stable bus.
               if (idx == IW'(N - 1))
                  state_reg <= FIN;
               else
                  idx <= idx + IW'(1);
            end
            FIN: begin
`ifdef NEURON_RELU_EN
               out <= (s_wide < 64'sd0) ? '0 : s_sat[OW-1:0];
`else
               out <= s_sat[OW-1:0];
`endif
               ready     <= 1'b1;
               busy      <= 1'b0;
               idx       <= '0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
